noc_port_requester: RTL

- Requester side of the router port-arbitration handshake: one instance per input port (L/N/E/W/S).
- Buffers incoming flits in a small FIFO and raises a request line toward the output-port arbiter.
- Drives the flit_id and length the arbiter's timeout timer samples, and streams flits out only while granted.
- Holds the request for the whole packet, pauses if the grant is withdrawn (timeout preemption), and releases after the tail flit.

---
 rtl/noc_port_requester_if.sv | 37 +++
 rtl/noc_port_requester.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/noc_port_requester_if.sv
// ---------------------------------------------------------------------------
// noc_port_requester_if
// Bundles the three handshakes of one router input port:
//   upstream   : in_valid / in_ready / in_flit_id / in_data
//   arbiter    : req / flit_id / length (to arbiter), grant (from arbiter)
//   downstream : out_valid / out_flit_id / out_data
// Modports:
//   master : the port requester (drives req, in_ready and the out_* signals)
//   slave  : the environment around it (upstream source, arbiter, sink)
// ---------------------------------------------------------------------------
interface noc_port_requester_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_flit_id;
    logic [DATA_W-1:0] in_data;

    logic              req;
    logic [2:0]        flit_id;
    logic [11:0]       length;
    logic              grant;

    logic              out_valid;
    logic [2:0]        out_flit_id;
    logic [DATA_W-1:0] out_data;

    modport master (
        input  in_valid, in_flit_id, in_data, grant,
        output in_ready, req, flit_id, length, out_valid, out_flit_id, out_data
    );

    modport slave (
        output in_valid, in_flit_id, in_data, grant,
        input  in_ready, req, flit_id, length, out_valid, out_flit_id, out_data
    );
endinterface

// File: rtl/noc_port_requester.sv
// ---------------------------------------------------------------------------
// noc_port_requester
// Requester side of the router port-arbitration handshake (one per input
// port). Incoming flits are buffered in a DEPTH-entry FIFO; when a header
// reaches the head, the packet length is latched and req is raised toward the
// output-port arbiter. Flits stream out (registered, 1-cycle latency) only
// while grant is high; req is held for the whole packet and dropped in the
// cycle the tail is registered out, followed by GAP_CYC idle cycles.
//
// Ports:
//   clk     : clock
//   rst     : synchronous reset, active-low
//   bus     : noc_port_requester_if.master (upstream, arbiter, downstream)
//   busy    : FSM not in IDLE
//   len_err : sticky length-mismatch flag
//
// Build option:
//   NOC_REQ_LEN_CHECK_EN - when defined, flits popped per packet are counted
//   and len_err is set on a mismatch with the header length; otherwise
//   len_err is tied to 0.
// ---------------------------------------------------------------------------
module noc_port_requester #(
    parameter int DATA_W  = 32,   // flit payload width, >= 12
    parameter int DEPTH   = 4,    // FIFO depth, power of two, >= 2
    parameter int GAP_CYC = 1     // idle cycles with req low after a tail
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_port_requester_if.master bus,
    output logic                 busy,
    output logic                 len_err
);
    localparam int AW       = $clog2(DEPTH);
    localparam int GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    localparam logic [2:0]  ID_HEAD  = 3'b001;
    localparam logic [2:0]  ID_TAIL  = 3'b100;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND, S_GAP} state_t;

    state_t state, next_state;

    // FIFO storage and control
    logic [2:0]        mem_id   [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       fill;
    logic              empty, full, push, pop;
    logic [2:0]        head_id;
    logic [DATA_W-1:0] head_data;

    // Packet tracking
    logic [11:0]       length_q;
    logic              hdr_sent;   // current packet's header already popped
    logic              send;       // pop that produces a downstream flit
    logic              latch_len;
    logic [GW-1:0]     gap_cnt;

    // Registered downstream outputs
    logic              out_valid_q;
    logic [2:0]        out_flit_id_q;
    logic [DATA_W-1:0] out_data_q;

    assign empty     = (fill == '0);
    assign full      = (fill == FULL_CNT);
    assign push      = bus.in_valid && !full;
    assign head_id   = mem_id[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // Next-state and pop decisions
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_state = state;
        pop        = 1'b0;
        send       = 1'b0;
        latch_len  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    if (head_id == ID_HEAD) begin
                        latch_len  = 1'b1;
                        next_state = S_REQ;
                    end else begin
                        pop = 1'b1;   // stray non-header flit is dropped
                    end
                end
            end
            S_REQ: begin
                if (bus.grant) next_state = S_SEND;
            end
            S_SEND: begin
                if (!empty) begin
                    if (head_id == ID_HEAD && hdr_sent) begin
                        // A new header closes the old packet; it stays queued.
                        next_state = (GAP_CYC == 0) ? S_IDLE : S_GAP;
                    end else if (bus.grant) begin
                        pop  = 1'b1;
                        send = 1'b1;
                        if (head_id == ID_TAIL)
                            next_state = (GAP_CYC == 0) ? S_IDLE : S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GW'(GAP_LAST)) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: FIFO storage has no reset; the fill count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]   <= bus.in_flit_id;
            mem_data[wr_ptr] <= bus.in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill          <= '0;
            length_q      <= '0;
            hdr_sent      <= 1'b0;
            gap_cnt       <= '0;
            out_valid_q   <= 1'b0;
            out_flit_id_q <= '0;
            out_data_q    <= '0;
        end else begin
            state <= next_state;

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fill <= fill + (AW+1)'(1);
            else if (pop && !push) fill <= fill - (AW+1)'(1);

            if (latch_len) length_q <= head_data[11:0];

            if (state != S_SEND) hdr_sent <= 1'b0;
            else if (send)       hdr_sent <= 1'b1;

            if (state == S_GAP) gap_cnt <= gap_cnt + GW'(1);
            else                gap_cnt <= '0;

            out_valid_q <= send;
            if (send) begin
                out_flit_id_q <= head_id;
                out_data_q    <= head_data;
            end
        end
    end

`ifdef NOC_REQ_LEN_CHECK_EN
    logic [11:0] pkt_cnt;
    logic [11:0] pkt_cnt_next;
    logic        len_err_q;

    assign pkt_cnt_next = pkt_cnt + 12'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_cnt   <= '0;
            len_err_q <= 1'b0;
        end else if (state != S_SEND) begin
            pkt_cnt <= '0;
        end else if (send) begin
            pkt_cnt <= pkt_cnt_next;
            // Tail short/long of the header length, or length reached without a tail.
            if ((head_id == ID_TAIL) != (pkt_cnt_next == length_q))
                len_err_q <= 1'b1;
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

    assign bus.in_ready    = !full;
    assign bus.req         = (state == S_REQ) || (state == S_SEND);
    assign bus.flit_id     = (bus.req && !empty) ? head_id : 3'b000;
    assign bus.length      = length_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_flit_id = out_flit_id_q;
    assign bus.out_data    = out_data_q;
    assign busy            = (state != S_IDLE);
endmodule
